ram_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the shared 64 KB RAM. It sits between the RAM instance and two masters: the CPU data port (requester 0) and the debug/program-loader port (requester 1). It grants the RAM round-robin, drives the RAM strobes for a configurable access time, and returns read data with a single-cycle acknowledge. Accesses to the ROM window are refused with an error instead of reaching the RAM.

---
 rtl/ram_arbiter_pkg.sv | 27 ++
 rtl/ram_arbiter_rr_arb2.sv | 31 +++
 rtl/ram_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// Module : ram_arbiter_pkg
// Brief  : Shared types and constants for the RAM arbiter and its sub-blocks.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic        REQ_CPU           = 1'b0;
  localparam logic        REQ_DBG           = 1'b1;
  localparam logic [15:0] ROM_LIMIT_DEFAULT = 16'h0100;
  localparam int          CNT_W             = 4;

  function automatic logic in_rom(input logic [15:0] addr, input logic [15:0] limit);
    return addr < limit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Combinational two-way round-robin pick; rr selects the winner
//          only when both requesters are active.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = REQ_CPU;
    if (req0 && req1) begin
      winner = rr;
    end else if (req1) begin
      winner = REQ_DBG;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module : ram_arbiter
// Brief  : Two-requester round-robin arbiter and access sequencer for the
//          shared 64 KB RAM, with ROM-window refusal.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [15:0] ROM_LIMIT   = ROM_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_re,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

  state_e             state_q, state_d;
  logic               rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               refused_q, refused_d;
  logic [15:0]        ram_addr_q, ram_addr_d;
  logic [7:0]         ram_wdata_q, ram_wdata_d;
  logic               ram_re_q, ram_re_d;
  logic               ram_we_q, ram_we_d;
  logic               busy_q, busy_d;
  logic               grant_q, grant_d;
  logic               ack0_q, ack0_d, ack1_q, ack1_d;
  logic               err0_q, err0_d, err1_q, err1_d;
  logic [7:0]         rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic               pick_valid;
  logic               pick_id;
  logic [15:0]        sel_addr;
  logic               sel_we;
  logic [7:0]         sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req0   (req0),
    .req1   (req1),
    .rr     (rr_q),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    refused_d   = refused_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_re_d    = ram_re_q;
    ram_we_d    = ram_we_q;
    busy_d      = busy_q;
    grant_d     = grant_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    sel_addr    = pick_id ? addr1  : addr0;
    sel_we      = pick_id ? we1    : we0;
    sel_wdata   = pick_id ? wdata1 : wdata0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d     = pick_id;
          ram_addr_d  = sel_addr;
          ram_wdata_d = sel_wdata;
          busy_d      = 1'b1;
          state_d     = ACCESS;
          // A refused access spends one strobe-less ACCESS cycle so its
          // acknowledge lands at a fixed two-cycle latency.
          if (in_rom(sel_addr, ROM_LIMIT)) begin
            refused_d = 1'b1;
            cnt_d     = '0;
            ram_re_d  = 1'b0;
            ram_we_d  = 1'b0;
          end else begin
            refused_d = 1'b0;
            cnt_d     = WAIT_LOAD;
            ram_re_d  = ~sel_we;
            ram_we_d  = sel_we;
          end
        end
      end

      ACCESS: begin
        if (cnt_q == '0) begin
          state_d  = DONE;
          ram_re_d = 1'b0;
          ram_we_d = 1'b0;
          ack0_d   = (grant_q == REQ_CPU);
          ack1_d   = (grant_q == REQ_DBG);
          err0_d   = refused_q && (grant_q == REQ_CPU);
          err1_d   = refused_q && (grant_q == REQ_DBG);
          if (ram_re_q) begin
            if (grant_q == REQ_DBG) begin
              rdata1_d = ram_rdata;
            end else begin
              rdata0_d = ram_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        rr_d    = ~grant_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      refused_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      grant_q     <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      refused_q   <= refused_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_re_q    <= ram_re_d;
      ram_we_q    <= ram_we_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_re    = ram_re_q;
  assign ram_we    = ram_we_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module : tb_ram_arbiter
// Brief  : Scoreboard bench for ram_arbiter: directed scenarios plus random
//          traffic from both requesters against a memory reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

  localparam logic [15:0] C_ROM = 16'h0100;
  localparam int          C_W   = 1;

  typedef struct packed {
    logic       err;
    logic [7:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [7:0]  wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, err0, err1, ram_re, ram_we, busy, grant_id;
  logic [7:0]  rdata0, rdata1, ram_wdata, ram_rdata;
  logic [15:0] ram_addr;

  logic        z_req0 = 1'b0;
  logic        z_zero = 1'b0;
  logic [15:0] z_addr0 = '0;
  logic        z_ack0, z_ack1, z_err0, z_err1, z_re, z_we, z_busy, z_gid;
  logic [7:0]  z_rdata0, z_rdata1, z_wdata, z_ram_rdata;
  logic [15:0] z_addr;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  model_rd [2];
  logic [7:0]  hold     [2];
  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  int          ack_log[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.WAIT_CYCLES(C_W), .ROM_LIMIT(C_ROM)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .busy(busy), .grant_id(grant_id)
  );

  ram_arbiter #(.WAIT_CYCLES(0), .ROM_LIMIT(C_ROM)) u_dut_z (
    .clk(clk), .reset(reset),
    .req0(z_req0), .req1(z_zero), .we0(z_zero), .we1(z_zero),
    .addr0(z_addr0), .addr1(16'h0000), .wdata0(8'h00), .wdata1(8'h00),
    .ack0(z_ack0), .ack1(z_ack1), .err0(z_err0), .err1(z_err1),
    .rdata0(z_rdata0), .rdata1(z_rdata1),
    .ram_addr(z_addr), .ram_wdata(z_wdata), .ram_re(z_re), .ram_we(z_we),
    .ram_rdata(z_ram_rdata), .busy(z_busy), .grant_id(z_gid)
  );

  assign ram_rdata   = mem[ram_addr];
  assign z_ram_rdata = mem[z_addr];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expectation derived from the access rules, not the FSM.
  task automatic push_exp(input int id, input logic we, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    if (a < C_ROM) begin
      e.err = 1'b1; e.rdata = model_rd[id];
    end else if (we) begin
      ref_mem[a] = d; e.err = 1'b0; e.rdata = model_rd[id];
    end else begin
      e.err = 1'b0; e.rdata = ref_mem[a]; model_rd[id] = ref_mem[a];
    end
    if (id == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
  endtask

  task automatic mon_port(input int id, input logic ack, input logic err, input logic [7:0] rd);
    exp_t e;
    if (ack) begin
      ack_log.push_back(id);
      if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_ack%0d: got ack expected none at %0t", id, $time);
      end else begin
        e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("err%0d", id), 32'(err), 32'(e.err));
        check($sformatf("rdata%0d", id), 32'(rd), 32'(e.rdata));
        hold[id] = e.rdata;
      end
    end else begin
      check($sformatf("err%0d_without_ack", id), 32'(err), 32'h0);
      check($sformatf("rdata%0d_hold", id), 32'(rd), 32'(hold[id]));
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      hold[0] = 8'h00; hold[1] = 8'h00;
    end else begin
      mon_port(0, ack0, err0, rdata0);
      mon_port(1, ack1, err1, rdata1);
      if (ram_re || ram_we) begin
        check("strobe_exclusive", 32'(ram_re & ram_we), 32'h0);
        check("strobe_outside_rom", 32'(ram_addr >= C_ROM), 32'h1);
      end
    end
  end

  task automatic setup(input int id, input logic we, input logic [15:0] a, input logic [7:0] d);
    if (id == 0) begin we0 = we; addr0 = a; wdata0 = d; end
    else begin we1 = we; addr1 = a; wdata1 = d; end
  endtask

  task automatic set_req(input int id, input logic r);
    if (id == 0) req0 = r; else req1 = r;
  endtask

  // Issue n back-to-back transactions with req held; cycle 0 is the first req cycle.
  task automatic run_req(input int id, input logic we, input logic [15:0] a, input logic [7:0] d,
                         input int n, output int ack_first, output int ack_last, output int strobes);
    int cyc = 0;
    int acks = 0;
    ack_first = -1; ack_last = -1; strobes = 0;
    @(posedge clk); #1;
    setup(id, we, a, d);
    set_req(id, 1'b1);
    for (int k = 0; k < n; k++) push_exp(id, we, a, d);
    while (acks < n && cyc < 60) begin
      @(negedge clk);
      if ((ram_re || ram_we) && grant_id == id[0]) strobes++;
      if ((id == 0) ? ack0 : ack1) begin
        acks++;
        if (ack_first < 0) ack_first = cyc;
        ack_last = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (acks < n) begin
      n_checks++; n_fail++;
      $display("FAIL ack_timeout%0d: got %0d acks expected %0d", id, acks, n);
    end
    set_req(id, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_rd[0] = 8'h00; model_rd[1] = 8'h00;
    ack_log.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int af, al, st, af2, al2, st2, zack, cyc;
    logic [7:0] rom_before;
    logic [15:0] a;

    for (int i = 0; i < 65536; i++) begin
      mem[16'(i)] = 8'($urandom);
      ref_mem[16'(i)] = mem[16'(i)];
    end
    mem[16'h0200] = 8'h5A; ref_mem[16'h0200] = 8'h5A;
    model_rd[0] = 8'h00; model_rd[1] = 8'h00;
    hold[0] = 8'h00; hold[1] = 8'h00;

    do_reset();
    @(negedge clk);
    check("rst_ack0", 32'(ack0), 0);      check("rst_ack1", 32'(ack1), 0);
    check("rst_err0", 32'(err0), 0);      check("rst_err1", 32'(err1), 0);
    check("rst_ram_re", 32'(ram_re), 0);  check("rst_ram_we", 32'(ram_we), 0);
    check("rst_busy", 32'(busy), 0);      check("rst_grant", 32'(grant_id), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_wdata", 32'(ram_wdata), 0);
    check("rst_rdata0", 32'(rdata0), 0);  check("rst_rdata1", 32'(rdata1), 0);

    // Single CPU read
    run_req(0, 1'b0, 16'h0200, 8'h00, 1, af, al, st);
    check("read_ack_cycle", 32'(af), 32'(2 + C_W));
    check("read_re_cycles", 32'(st), 32'(1 + C_W));

    // Collision right after reset: requester 0 first
    do_reset();
    fork
      run_req(0, 1'b1, 16'h0300, 8'h11, 1, af, al, st);
      run_req(1, 1'b1, 16'h0301, 8'h22, 1, af2, al2, st2);
    join
    check("collide1_count", 32'(ack_log.size()), 2);
    if (ack_log.size() >= 2) begin
      check("collide1_first", 32'(ack_log[0]), 0);
      check("collide1_second", 32'(ack_log[1]), 1);
    end
    check("mem_0300", 32'(mem[16'h0300]), 32'h11);
    check("mem_0301", 32'(mem[16'h0301]), 32'h22);

    // After a lone requester-0 grant the pointer favours requester 1
    run_req(0, 1'b0, 16'h0300, 8'h00, 1, af, al, st);
    ack_log.delete();
    fork
      run_req(0, 1'b0, 16'h0301, 8'h00, 1, af, al, st);
      run_req(1, 1'b0, 16'h0300, 8'h00, 1, af2, al2, st2);
    join
    check("collide2_count", 32'(ack_log.size()), 2);
    if (ack_log.size() >= 2) check("collide2_first", 32'(ack_log[0]), 1);

    // ROM-window refusal
    rom_before = mem[16'h00FF];
    run_req(1, 1'b1, 16'h00FF, 8'hAB, 1, af, al, st);
    check("rom_ack_cycle", 32'(af), 2);
    check("rom_strobes", 32'(st), 0);
    check("rom_mem_unchanged", 32'(mem[16'h00FF]), 32'(rom_before));

    // Reset in the second ACCESS cycle of a write, with rr pointing at requester 1
    run_req(0, 1'b0, 16'h0200, 8'h00, 1, af, al, st);
    @(posedge clk); #1;
    setup(0, 1'b1, 16'h0400, 8'h77);
    req0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_we_active", 32'(ram_we), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    req0 = 1'b0;
    model_rd[0] = 8'h00; model_rd[1] = 8'h00;
    @(negedge clk);
    check("abort_we_low", 32'(ram_we), 0);
    check("abort_re_low", 32'(ram_re), 0);
    check("abort_busy_low", 32'(busy), 0);
    check("abort_no_ack", 32'(ack0), 0);
    ack_log.delete();
    fork
      run_req(0, 1'b0, 16'h1000, 8'h00, 1, af, al, st);
      run_req(1, 1'b0, 16'h2000, 8'h00, 1, af2, al2, st2);
    join
    check("abort_count", 32'(ack_log.size()), 2);
    if (ack_log.size() >= 1) check("abort_rr_reset_first", 32'(ack_log[0]), 0);

    // Held request: two identical reads with one IDLE cycle between them
    run_req(0, 1'b0, 16'h0500, 8'h00, 2, af, al, st);
    check("held_ack_gap", 32'(al - af), 32'(C_W + 3));

    // Zero wait states on the second instance
    @(posedge clk); #1;
    z_addr0 = 16'hFFFF;
    z_req0 = 1'b1;
    zack = -1;
    cyc = 0;
    while (zack < 0 && cyc < 20) begin
      @(negedge clk);
      if (z_ack0) begin
        zack = cyc;
        check("zero_rdata", 32'(z_rdata0), 32'(ref_mem[16'hFFFF]));
        check("zero_err", 32'(z_err0), 0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    z_req0 = 1'b0;
    check("zero_ack_cycle", 32'(zack), 2);

    // Random traffic from both requesters in disjoint RAM regions plus ROM hits
    fork
      begin
        int f, l, s;
        for (int t = 0; t < 30; t++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(0, 255));
          else a = 16'h1000 + 16'($urandom_range(0, 255));
          run_req(0, 1'($urandom_range(0, 1)), a, 8'($urandom), 1, f, l, s);
        end
      end
      begin
        int f, l, s;
        logic [15:0] b;
        for (int t = 0; t < 30; t++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          if ($urandom_range(0, 7) == 0) b = 16'($urandom_range(0, 255));
          else b = 16'h2000 + 16'($urandom_range(0, 255));
          run_req(1, 1'($urandom_range(0, 1)), b, 8'($urandom), 1, f, l, s);
        end
      end
    join

    repeat (4) @(posedge clk);
    check("exp_q0_drained", 32'(exp_q0.size()), 0);
    check("exp_q1_drained", 32'(exp_q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
